// File: rtl/apb_rw_regs.sv
// APB4 register file: per-register RW flops or RO mirrors, byte strobes, hardware update port, write-notify pulses.
// Latency: pready after WAIT_CYCLES extra access cycles, writes visible one edge later; backpressure via pready_o only.
module apb_rw_regs #(
  parameter int                            ADDR_WIDTH  = 12,
  parameter int                            DATA_WIDTH  = 32,
  parameter int                            N_REGS      = 4,
  parameter logic [N_REGS-1:0]             RO_MASK     = '0,
  parameter logic [N_REGS*DATA_WIDTH-1:0]  RST_VAL     = '0,
  parameter int                            WAIT_CYCLES = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           psel_i,
  input  logic                           penable_i,
  input  logic                           pwrite_i,
  input  logic [ADDR_WIDTH-1:0]          paddr_i,
  input  logic [DATA_WIDTH-1:0]          pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]        pstrb_i,
  output logic [DATA_WIDTH-1:0]          prdata_o,
  output logic                           pready_o,
  output logic                           pslverr_o,
  input  logic [N_REGS*DATA_WIDTH-1:0]   reg_ro_i,
  input  logic [N_REGS-1:0]              hw_wr_i,
  input  logic [N_REGS*DATA_WIDTH-1:0]   hw_wdata_i,
  output logic [N_REGS*DATA_WIDTH-1:0]   reg_o,
  output logic [N_REGS-1:0]              reg_wr_o
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(NBYTES);
  localparam int IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  ro_hit;
  logic                  err;
  logic                  access;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] rd_vals [N_REGS];
  logic                  unused_ok;

  // Upper address bits all take part in the range check, so aliases above N_REGS error out.
  assign word_addr = paddr_i >> OFFS;
  assign idx       = word_addr[IDX_W-1:0];
  assign in_range  = (word_addr < ADDR_WIDTH'(N_REGS));

  assign access   = psel_i & penable_i & ~rst_i;
  assign pready_o = access & (cnt == CNT_W'(WAIT_CYCLES));

  always_comb begin
    ro_hit = 1'b0;
    rd_mux = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (in_range && (idx == IDX_W'(i))) begin
        ro_hit = RO_MASK[i];
        rd_mux = rd_vals[i];
      end
    end
  end

  assign err       = ~in_range | (pwrite_i & ro_hit);
  assign pslverr_o = pready_o & err;
  assign commit    = pready_o & pwrite_i & ~err;
  assign prdata_o  = (pready_o & ~pwrite_i & ~err) ? rd_mux : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i || !psel_i || !penable_i || pready_o) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign rd_vals[i]                              = reg_ro_i[i*DATA_WIDTH +: DATA_WIDTH];
      assign reg_o[i*DATA_WIDTH +: DATA_WIDTH]       = '0;
      assign reg_wr_o[i]                             = 1'b0;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q;
      logic                  wr_q;
      logic                  hit;

      assign hit = commit & (idx == IDX_W'(i));

      // Strobed bytes from APB win; the rest follow a concurrent hardware update.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          q    <= RST_VAL[i*DATA_WIDTH +: DATA_WIDTH];
          wr_q <= 1'b0;
        end else begin
          wr_q <= hit;
          for (int b = 0; b < NBYTES; b++) begin
            if (hit && pstrb_i[b]) begin
              q[b*8 +: 8] <= pwdata_i[b*8 +: 8];
            end else if (hw_wr_i[i]) begin
              q[b*8 +: 8] <= hw_wdata_i[i*DATA_WIDTH + b*8 +: 8];
            end
          end
        end
      end

      assign rd_vals[i]                        = q;
      assign reg_o[i*DATA_WIDTH +: DATA_WIDTH] = q;
      assign reg_wr_o[i]                       = wr_q;
    end
  end

  // RO slices of the hardware ports and RW slices of reg_ro_i are intentionally ignored.
  assign unused_ok = ^{reg_ro_i, hw_wdata_i, hw_wr_i};

  if (N_REGS < 1) begin : g_chk_nregs
    $error("apb_rw_regs: N_REGS must be >= 1");
  end
  if ((DATA_WIDTH < 8) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_chk_dw
    $error("apb_rw_regs: DATA_WIDTH must be a power of 2 and >= 8");
  end
  if (WAIT_CYCLES > 15) begin : g_chk_wait
    $error("apb_rw_regs: WAIT_CYCLES must be <= 15");
  end

endmodule
